// File: rtl/latch_wr_arbiter_pkg.sv
// Shared types and constant helpers for the latch bank write arbiter.
package latch_wr_arbiter_pkg;

    // One-hot sequencer states.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SETUP  = 5'b00010,
        ST_ENABLE = 5'b00100,
        ST_HOLD   = 5'b01000,
        ST_ACK    = 5'b10000
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Index width for n requesters, never narrower than one bit.
    function automatic int idw_of(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    // Phase counter width: holds the largest (phase length - 1).
    function automatic int cnt_width(input int s, input int e, input int h);
        return (clog2(max3(s, e, h)) > 1) ? clog2(max3(s, e, h)) : 1;
    endfunction

endpackage

// File: rtl/latch_wr_arbiter_if.sv
// Requester-side and latch-bank-side signal bundle of the write arbiter.
interface latch_wr_arbiter_if
    import latch_wr_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int LATCH_BITS = 8
);
    localparam int IDW = idw_of(NREQ);

    logic [NREQ-1:0]            req;
    logic [NREQ*LATCH_BITS-1:0] wdata;
    logic [NREQ-1:0]            ack;
    logic                       lat_en;
    logic [LATCH_BITS-1:0]      lat_d;
    logic                       lat_rstn;
    logic                       busy;
    logic [IDW-1:0]             grant_id;

    modport master (
        output req, wdata,
        input  ack, lat_en, lat_d, lat_rstn, busy, grant_id
    );

    modport slave (
        input  req, wdata,
        output ack, lat_en, lat_d, lat_rstn, busy, grant_id
    );

endinterface

// File: rtl/latch_wr_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first set request at or after the pointer.
module latch_wr_arbiter_rr_arbiter
    import latch_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_gnt,
    output logic            o_vld
);

    // Scan NREQ positions starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((32'(i_ptr) + i) % NREQ);
            if (!o_vld && i_req[idx]) begin
                o_gnt = idx;
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Round-robin writer arbitration for a latch bank: setup / enable / hold
// sequencing with every bank pin driven straight from a flop, plus a
// 4-phase ack back to the winning requester.
module latch_wr_arbiter
    import latch_wr_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int LATCH_BITS = 8,
    parameter int SETUP_CYC  = 1,
    parameter int EN_CYC     = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic                clk,
    input  logic                rstn,
    latch_wr_arbiter_if.slave   bus
);

    localparam int IDW = idw_of(NREQ);
    localparam int CW  = cnt_width(SETUP_CYC, EN_CYC, HOLD_CYC);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [IDW-1:0]        r_ptr, w_ptr_nxt;
    logic [IDW-1:0]        r_gid, w_gid_nxt;
    logic [NREQ-1:0]       r_ack, w_ack_nxt;
    logic                  r_lat_en, w_lat_en_nxt;
    logic [LATCH_BITS-1:0] r_lat_d, w_lat_d_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_lat_rstn;
    logic [IDW-1:0]        w_pick;
    logic                  w_pick_vld;

    latch_wr_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_vld (w_pick_vld)
    );

    // Next-state and next-output decode; every output register is loaded from here.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_gid_nxt    = r_gid;
        w_ack_nxt    = r_ack;
        w_lat_en_nxt = r_lat_en;
        w_lat_d_nxt  = r_lat_d;
        w_busy_nxt   = r_busy;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_gid_nxt  = w_pick;
                    for (int unsigned k = 0; k < NREQ; k++) begin
                        if (w_pick == IDW'(k))
                            w_lat_d_nxt = bus.wdata[k*LATCH_BITS +: LATCH_BITS];
                    end
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = CW'(SETUP_CYC - 1);
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_lat_en_nxt = 1'b1;
                    w_cnt_nxt    = CW'(EN_CYC - 1);
                    w_state_nxt  = ST_ENABLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ENABLE: begin
                if (r_cnt == '0) begin
                    w_lat_en_nxt = 1'b0;
                    w_cnt_nxt    = CW'(HOLD_CYC - 1);
                    w_state_nxt  = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_ack_nxt        = '0;
                    w_ack_nxt[r_gid] = 1'b1;
                    w_state_nxt      = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                if (!bus.req[r_gid]) begin
                    w_ack_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; lat_rstn mirrors rstn one edge late.
    always_ff @(posedge clk) begin
        r_lat_rstn <= rstn;
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_gid    <= '0;
            r_ack    <= '0;
            r_lat_en <= 1'b0;
            r_lat_d  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gid    <= w_gid_nxt;
            r_ack    <= w_ack_nxt;
            r_lat_en <= w_lat_en_nxt;
            r_lat_d  <= w_lat_d_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.lat_en   = r_lat_en;
    assign bus.lat_d    = r_lat_d;
    assign bus.lat_rstn = r_lat_rstn;
    assign bus.busy     = r_busy;
    assign bus.grant_id = r_gid;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Bench for latch_wr_arbiter: a default-timing instance and a long-phase
// instance, both checked every cycle against a transaction timeline model.
module tb_latch_wr_arbiter;

    localparam int L_S = 3;
    localparam int L_E = 2;
    localparam int L_H = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_v [2];
    logic [31:0] wd_v  [2];

    logic [3:0] o_ack  [2];
    logic       o_en   [2];
    logic [7:0] o_d    [2];
    logic       o_lrst [2];
    logic       o_busy [2];
    logic [1:0] o_gid  [2];

    latch_wr_arbiter_if #(.NREQ(4), .LATCH_BITS(8)) bus0 ();
    latch_wr_arbiter_if #(.NREQ(4), .LATCH_BITS(8)) bus1 ();

    latch_wr_arbiter #(.NREQ(4), .LATCH_BITS(8)) dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    latch_wr_arbiter #(
        .NREQ(4), .LATCH_BITS(8),
        .SETUP_CYC(L_S), .EN_CYC(L_E), .HOLD_CYC(L_H)
    ) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    assign bus0.req   = req_v[0];
    assign bus0.wdata = wd_v[0];
    assign bus1.req   = req_v[1];
    assign bus1.wdata = wd_v[1];
    assign o_ack[0] = bus0.ack;   assign o_ack[1] = bus1.ack;
    assign o_en[0]  = bus0.lat_en; assign o_en[1] = bus1.lat_en;
    assign o_d[0]   = bus0.lat_d;  assign o_d[1]  = bus1.lat_d;
    assign o_lrst[0] = bus0.lat_rstn; assign o_lrst[1] = bus1.lat_rstn;
    assign o_busy[0] = bus0.busy;  assign o_busy[1] = bus1.busy;
    assign o_gid[0] = bus0.grant_id; assign o_gid[1] = bus1.grant_id;

    int nchk = 0;
    int npass = 0;
    int n = 0;

    // Timeline model: a write granted at edge k has fixed phase offsets.
    int S [2];
    int E [2];
    int H [2];
    bit         m_act  [2];
    int         m_k    [2];
    int         m_g    [2];
    int         m_ptr  [2];
    logic [7:0] m_d    [2];
    int         m_gid  [2];
    bit         m_lrst [2];
    logic [7:0] bank_exp [2];
    logic [7:0] bank_dut [2];
    logic       prev_en [2];
    logic [7:0] prev_d  [2];

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s #%0d: got %0h expected %0h (t=%0t)", name, tag, act, exp, $time);
    endtask

    task automatic model_edge(input int d);
        bit found;
        if (!rstn) begin
            m_act[d] = 0; m_ptr[d] = 0; m_d[d] = '0; m_gid[d] = 0; m_lrst[d] = 0;
        end else begin
            m_lrst[d] = 1;
            if (m_act[d]) begin
                if ((n - m_k[d]) > S[d] + E[d] + H[d] && !req_v[d][m_g[d]]) begin
                    m_act[d] = 0;
                    m_ptr[d] = (m_g[d] + 1) % 4;
                end
            end else if (req_v[d] != 4'b0000) begin
                found = 0;
                for (int off = 0; off < 4; off++) begin
                    int c;
                    c = (m_ptr[d] + off) % 4;
                    if (!found && req_v[d][c]) begin
                        m_g[d] = c;
                        found = 1;
                    end
                end
                m_act[d] = 1;
                m_k[d]   = n;
                m_gid[d] = m_g[d];
                m_d[d]   = wd_v[d][m_g[d]*8 +: 8];
            end
        end
    endtask

    task automatic check_outputs(input int d);
        int ph;
        logic [3:0] eack;
        logic een;
        ph   = n - m_k[d];
        een  = m_act[d] && ph >= S[d] && ph < S[d] + E[d];
        eack = (m_act[d] && ph >= S[d] + E[d] + H[d]) ? (4'b0001 << m_g[d]) : 4'b0000;
        chk("ack", d, o_ack[d], eack);
        chk("lat_en", d, o_en[d], een);
        chk("lat_d", d, o_d[d], m_d[d]);
        chk("busy", d, o_busy[d], m_act[d]);
        chk("grant_id", d, o_gid[d], m_gid[d]);
        chk("lat_rstn", d, o_lrst[d], m_lrst[d]);
        if (!m_lrst[d]) bank_exp[d] = '0;
        else if (een) bank_exp[d] = m_d[d];
        if (!o_lrst[d]) bank_dut[d] = '0;
        else if (o_en[d]) bank_dut[d] = o_d[d];
        chk("bank_q", d, bank_dut[d], bank_exp[d]);
        if (o_en[d] === 1'b1 && prev_en[d] === 1'b1)
            chk("lat_d_stable_while_en", d, o_d[d], prev_d[d]);
        prev_en[d] = o_en[d];
        prev_d[d]  = o_d[d];
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic       rstn;
        logic [3:0] req;
        logic [3:0] ack;
        logic       en;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] d;
        logic       lrst;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acks;
        int en_cnt;
        int first;
        int k;
        logic [7:0] sl;

        S[0] = 1;   E[0] = 1;   H[0] = 1;
        S[1] = L_S; E[1] = L_E; H[1] = L_H;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_k[d] = 0; m_g[d] = 0; m_ptr[d] = 0; m_d[d] = '0;
            m_gid[d] = 0; m_lrst[d] = 0; bank_exp[d] = '0; bank_dut[d] = '0;
            prev_en[d] = 1'b0; prev_d[d] = '0;
        end
        req_v[0] = 4'b0000; req_v[1] = 4'b0000;
        wd_v[0] = 32'h33A52211;
        wd_v[1] = 32'h445C2211;

        //            rstn  req      ack      en    busy  gid    d       lrst
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1};
        tbl[4]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1};
        tbl[5]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b1};
        tbl[6]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1};
        tbl[7]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1};
        tbl[8]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1};

        // Reset and a single writer on requester 2.
        for (int i = 0; i < 11; i++) begin
            rstn = tbl[i].rstn;
            req_v[0] = tbl[i].req;
            step();
            chk("tbl_ack", i, o_ack[0], tbl[i].ack);
            chk("tbl_lat_en", i, o_en[0], tbl[i].en);
            chk("tbl_busy", i, o_busy[0], tbl[i].busy);
            chk("tbl_grant_id", i, o_gid[0], tbl[i].gid);
            chk("tbl_lat_d", i, o_d[0], tbl[i].d);
            chk("tbl_lat_rstn", i, o_lrst[0], tbl[i].lrst);
        end
        chk("single_bank_q", 0, bank_dut[0], 8'hA5);

        // Round robin with all requests held, each releasing on its ack.
        do_reset();
        req_v[0] = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            t = 0;
            while (o_ack[0] == 4'b0000 && t < 20) begin step(); t++; end
            chk("rr_ack_wait", j, (t < 20), 1);
            chk("rr_grant_id", j, o_gid[0], j % 4);
            sl = wd_v[0][(j % 4)*8 +: 8];
            chk("rr_lat_d", j, o_d[0], sl);
            req_v[0][j % 4] = 1'b0;
            step();
            req_v[0] = 4'b1111;
        end
        req_v[0] = 4'b0000;
        step();

        // Long phases on the second instance.
        req_v[1] = 4'b0100;
        t = 0;
        while (o_busy[1] !== 1'b1 && t < 20) begin step(); t++; end
        chk("long_grant_wait", 1, (t < 20), 1);
        k = n;
        en_cnt = 0;
        first = -1;
        t = 0;
        while (o_ack[1] == 4'b0000 && t < 30) begin
            step();
            t++;
            if (o_en[1] === 1'b1) begin
                en_cnt++;
                if (first < 0) first = n - k;
            end
        end
        chk("long_ack_wait", 1, (t < 30), 1);
        chk("long_en_cycles", 1, en_cnt, 2);
        chk("long_en_offset", 1, first, 3);
        chk("long_ack_offset", 1, n - k, 7);
        chk("long_lat_d", 1, o_d[1], 8'h5C);
        chk("long_bank_q", 1, bank_dut[1], 8'h5C);
        req_v[1] = 4'b0000;
        step();
        step();

        // Early drop: requester 1 releases during the enable pulse.
        req_v[0] = 4'b0010;
        t = 0;
        while (o_en[0] !== 1'b1 && t < 20) begin step(); t++; end
        chk("early_en_wait", 0, (t < 20), 1);
        req_v[0] = 4'b0000;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_ack[0][1] === 1'b1) acks++;
        end
        chk("early_ack_cycles", 0, acks, 1);
        chk("early_busy_after", 0, o_busy[0], 1'b0);
        chk("early_bank_q", 0, bank_dut[0], 8'h22);

        // Reset while the enable pulse is high; pointer must return to 0.
        req_v[0] = 4'b1001;
        t = 0;
        while (o_en[0] !== 1'b1 && t < 20) begin step(); t++; end
        chk("rstmid_en_wait", 0, (t < 20), 1);
        chk("rstmid_pre_gid", 0, o_gid[0], 3);
        rstn = 1'b0;
        step();
        chk("rstmid_lat_en", 0, o_en[0], 1'b0);
        chk("rstmid_lat_d", 0, o_d[0], 8'h00);
        chk("rstmid_lat_rstn", 0, o_lrst[0], 1'b0);
        chk("rstmid_ack", 0, o_ack[0], 4'b0000);
        chk("rstmid_bank_q", 0, bank_dut[0], 8'h00);
        rstn = 1'b1;
        step();
        chk("rstmid_regrant_gid", 0, o_gid[0], 0);
        chk("rstmid_regrant_busy", 0, o_busy[0], 1'b1);
        chk("rstmid_lat_rstn_up", 0, o_lrst[0], 1'b1);
        req_v[0] = 4'b0000;
        for (int c = 0; c < 8; c++) step();

        // Random traffic on both instances, with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rstn = ($urandom_range(0, 79) != 0);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 3) == 0) req_v[d] = 4'($urandom);
                if ($urandom_range(0, 1) == 0) wd_v[d] = $urandom;
            end
            step();
        end
        rstn = 1'b1;
        req_v[0] = 4'b0000;
        req_v[1] = 4'b0000;
        for (int c = 0; c < 12; c++) step();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
